// File: rtl/mips150_io_uart.sv
// MIPS150 memory-mapped IO block: UART TX/RX plus a free-running cycle counter.
// Stores commit at the X-stage edge; loads return one cycle later, like the DMEM read.
module mips150_io_uart #(
    parameter int unsigned CLOCK_FREQ     = 50_000_000,
    parameter int unsigned BAUD_RATE      = 115_200,
    parameter int unsigned CYCLES_PER_BIT = CLOCK_FREQ / BAUD_RATE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] io_addr,
    input  logic [3:0]  io_we,
    input  logic [31:0] io_wdata,
    input  logic        io_re,
    output logic [31:0] io_rdata,
    input  logic        serial_in,
    output logic        serial_out
);

    localparam int unsigned CW = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST_TICK = CW'(CYCLES_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_TICK = CW'((CYCLES_PER_BIT >= 2) ? CYCLES_PER_BIT / 2 - 1 : 0);

    localparam logic [5:0] SEL_TX_STATUS = 6'h00;
    localparam logic [5:0] SEL_RX_STATUS = 6'h01;
    localparam logic [5:0] SEL_RX_DATA   = 6'h02;
    localparam logic [5:0] SEL_TX_DATA   = 6'h03;
    localparam logic [5:0] SEL_CYCLE     = 6'h04;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uartState_t;

    logic [5:0]  regSel;
    logic        ioWrite, txWrite, cycleClear, rxPop, rxStatusRead;
    logic [31:0] readMux;
    logic [31:0] cycleCount;
    logic        unusedBits;

    assign regSel       = io_addr[7:2];
    assign ioWrite      = |io_we;
    assign txWrite      = ioWrite && (regSel == SEL_TX_DATA);
    assign cycleClear   = ioWrite && (regSel == SEL_CYCLE);
    assign rxPop        = io_re && (regSel == SEL_RX_DATA);
    assign rxStatusRead = io_re && (regSel == SEL_RX_STATUS);
    assign unusedBits   = ^{io_addr[31:8], io_addr[1:0], io_wdata[31:8]};

    // ---------------- TX ----------------
    uartState_t      txState, txStateNext;
    logic [CW-1:0]   txCnt, txCntNext;
    logic [2:0]      txIdx, txIdxNext;
    logic [7:0]      txShift, txShiftNext;
    logic            serialOutNext;
    logic            txReady;

    // Ready during the final stop cycle, so a write there starts the next frame back-to-back.
    assign txReady = (txState == IDLE) || ((txState == STOP) && (txCnt == LAST_TICK));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txState    <= IDLE;
            txCnt      <= '0;
            txIdx      <= '0;
            txShift    <= '0;
            serial_out <= 1'b1;
        end else begin
            txState    <= txStateNext;
            txCnt      <= txCntNext;
            txIdx      <= txIdxNext;
            txShift    <= txShiftNext;
            serial_out <= serialOutNext;
        end
    end

    always_comb begin
        txStateNext   = txState;
        txCntNext     = txCnt;
        txIdxNext     = txIdx;
        txShiftNext   = txShift;
        serialOutNext = serial_out;
        case (txState)
            IDLE: serialOutNext = 1'b1;
            START: begin
                if (txCnt == LAST_TICK) begin
                    txStateNext   = DATA;
                    txCntNext     = '0;
                    txIdxNext     = '0;
                    serialOutNext = txShift[0];
                end else begin
                    txCntNext = txCnt + CW'(1);
                end
            end
            DATA: begin
                if (txCnt == LAST_TICK) begin
                    txCntNext   = '0;
                    txShiftNext = {1'b0, txShift[7:1]};
                    if (txIdx == 3'd7) begin
                        txStateNext   = STOP;
                        serialOutNext = 1'b1;
                    end else begin
                        txIdxNext     = txIdx + 3'd1;
                        serialOutNext = txShift[1];
                    end
                end else begin
                    txCntNext = txCnt + CW'(1);
                end
            end
            STOP: begin
                if (txCnt == LAST_TICK) begin
                    txStateNext = IDLE;
                    txCntNext   = '0;
                end else begin
                    txCntNext = txCnt + CW'(1);
                end
            end
            default: txStateNext = IDLE;
        endcase
        if (txWrite && txReady) begin
            txStateNext   = START;
            txCntNext     = '0;
            txShiftNext   = io_wdata[7:0];
            serialOutNext = 1'b0;
        end
    end

    // ---------------- RX ----------------
    uartState_t      rxState, rxStateNext;
    logic [CW-1:0]   rxCnt, rxCntNext;
    logic [2:0]      rxIdx, rxIdxNext;
    logic [7:0]      rxShift, rxShiftNext;
    logic            rxMeta, rxSync, rxCommit;
    logic [7:0]      rxData;
    logic            rxValid, rxOverrun;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxMeta  <= 1'b1;
            rxSync  <= 1'b1;
            rxState <= IDLE;
            rxCnt   <= '0;
            rxIdx   <= '0;
            rxShift <= '0;
        end else begin
            rxMeta  <= serial_in;
            rxSync  <= rxMeta;
            rxState <= rxStateNext;
            rxCnt   <= rxCntNext;
            rxIdx   <= rxIdxNext;
            rxShift <= rxShiftNext;
        end
    end

    always_comb begin
        rxStateNext = rxState;
        rxCntNext   = rxCnt;
        rxIdxNext   = rxIdx;
        rxShiftNext = rxShift;
        rxCommit    = 1'b0;
        case (rxState)
            IDLE: begin
                if (!rxSync) begin
                    rxStateNext = START;
                    rxCntNext   = '0;
                end
            end
            START: begin
                if (rxCnt == HALF_TICK) begin
                    rxStateNext = rxSync ? IDLE : DATA;
                    rxCntNext   = '0;
                    rxIdxNext   = '0;
                end else begin
                    rxCntNext = rxCnt + CW'(1);
                end
            end
            DATA: begin
                if (rxCnt == LAST_TICK) begin
                    rxCntNext   = '0;
                    rxShiftNext = {rxSync, rxShift[7:1]};
                    if (rxIdx == 3'd7) rxStateNext = STOP;
                    else               rxIdxNext   = rxIdx + 3'd1;
                end else begin
                    rxCntNext = rxCnt + CW'(1);
                end
            end
            STOP: begin
                if (rxCnt == LAST_TICK) begin
                    rxStateNext = IDLE;
                    rxCntNext   = '0;
                    rxCommit    = rxSync;
                end else begin
                    rxCntNext = rxCnt + CW'(1);
                end
            end
            default: rxStateNext = IDLE;
        endcase
    end

    // ---------------- Register file and load path ----------------
    always_comb begin
        readMux = '0;
        case (regSel)
            SEL_TX_STATUS: readMux = {31'b0, txReady};
            SEL_RX_STATUS: readMux = {30'b0, rxOverrun, rxValid};
            SEL_RX_DATA:   readMux = {24'b0, rxData};
            SEL_CYCLE:     readMux = cycleCount;
            default:       readMux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            io_rdata   <= '0;
            rxData     <= '0;
            rxValid    <= 1'b0;
            rxOverrun  <= 1'b0;
            cycleCount <= '0;
        end else begin
            io_rdata <= io_re ? readMux : '0;
            if (rxCommit) rxData <= rxShift;
            if (rxCommit)   rxValid <= 1'b1;
            else if (rxPop) rxValid <= 1'b0;
            // A pop landing on the commit edge consumes the old byte, so it is not an overrun.
            if (rxCommit && rxValid && !rxPop) rxOverrun <= 1'b1;
            else if (rxStatusRead)             rxOverrun <= 1'b0;
            if (cycleClear) cycleCount <= '0;
            else            cycleCount <= cycleCount + 32'd1;
        end
    end

endmodule
